// File: rtl/trap_unit_pkg.sv
// Shared types for the trap path: trap-condition field layout, its bit
// indices, and the trap unit state encoding.
package trap_unit_pkg;

    // Bit positions of the five relations inside the TO field
    localparam int TO_LT  = 4;   // a < b, signed
    localparam int TO_GT  = 3;   // a > b, signed
    localparam int TO_EQ  = 2;   // a == b
    localparam int TO_LTU = 1;   // a < b, unsigned
    localparam int TO_GTU = 0;   // a > b, unsigned

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic ltu;
        logic gtu;
    } trap_to_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        REQ  = 2'd2
    } trap_state_t;

endpackage

// File: rtl/trap_cond.sv
// Combinational trap-condition evaluator: hit is the OR of every relation
// selected in TO, evaluated on operands a and b.
module trap_cond
    import trap_unit_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [4:0]        to,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              hit
);

    logic signed [WORD_W-1:0] a_s;
    logic signed [WORD_W-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    // Each selected relation contributes independently; TO=0 can never hit
    always_comb begin
        hit = (to[TO_LT]  & (a_s < b_s)) |
              (to[TO_GT]  & (a_s > b_s)) |
              (to[TO_EQ]  & (a == b))    |
              (to[TO_LTU] & (a < b))     |
              (to[TO_GTU] & (a > b));
    end

endmodule

// File: rtl/trap_unit.sv
// Trap unit: accepts a tw/twi-class instruction from decode, evaluates its
// condition one cycle later, and either pulses done or holds a trap request
// to the exception controller until it is acknowledged or flushed.
// Optional feature: define TRAP_UNIT_COUNTER_EN to add a saturating count of
// acknowledged traps (trap_count) with a synchronous clear (trap_count_clr).
module trap_unit
    import trap_unit_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [4:0]        to,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] pc,
    input  logic              flush,
    output logic              done,
    output logic              trap_req,
    output logic [WORD_W-1:0] trap_pc,
    input  logic              trap_ack
`ifdef TRAP_UNIT_COUNTER_EN
    ,
    output logic [31:0]       trap_count,
    input  logic              trap_count_clr
`endif
);

    trap_state_t       state_q, state_d;
    trap_to_t          to_q, to_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] trap_pc_q, trap_pc_d;
    logic              hit;
    logic              ack_exit;

    trap_cond #(.WORD_W(WORD_W)) u_cond (
        .to  (to_q),
        .a   (a_q),
        .b   (b_q),
        .hit (hit)
    );

    // Next-state, operand capture and handshake outputs; flush overrides
    // both the hit decision and trap_ack
    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        a_d       = a_q;
        b_d       = b_q;
        pc_d      = pc_q;
        trap_pc_d = trap_pc_q;
        ready_out = 1'b0;
        done      = 1'b0;
        trap_req  = 1'b0;
        ack_exit  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in && !flush) begin
                    to_d    = trap_to_t'(to);
                    a_d     = a;
                    b_d     = b;
                    pc_d    = pc;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (hit) begin
                    trap_pc_d = pc_q;
                    state_d   = REQ;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            REQ: begin
                trap_req = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else if (trap_ack) begin
                    ack_exit = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and operand registers, all cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            to_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            pc_q      <= '0;
            trap_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            to_q      <= to_d;
            a_q       <= a_d;
            b_q       <= b_d;
            pc_q      <= pc_d;
            trap_pc_q <= trap_pc_d;
        end
    end

    assign trap_pc = trap_pc_q;

`ifdef TRAP_UNIT_COUNTER_EN
    logic [31:0] trap_count_q, trap_count_d;

    // Saturating count of acknowledged traps; clear beats increment
    always_comb begin
        trap_count_d = trap_count_q;
        if (trap_count_clr) begin
            trap_count_d = '0;
        end else if (ack_exit && (trap_count_q != 32'hFFFF_FFFF)) begin
            trap_count_d = trap_count_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap_count_q <= '0;
        end else begin
            trap_count_q <= trap_count_d;
        end
    end

    assign trap_count = trap_count_q;
`else
    logic unused_ack_exit;
    assign unused_ack_exit = ack_exit;
`endif

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_trap_unit;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        ready_out;
    logic [4:0]  to;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic        flush;
    logic        done;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic        trap_ack;
    logic        tclr;
`ifdef TRAP_UNIT_COUNTER_EN
    logic [31:0] trap_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_inflight;
    bit          m_pend;
    logic [4:0]  m_to;
    logic [31:0] m_a, m_b, m_pc, m_tpc;
    logic [31:0] m_cnt;

    trap_unit #(.WORD_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .to       (to),
        .a        (a),
        .b        (b),
        .pc       (pc),
        .flush    (flush),
        .done     (done),
        .trap_req (trap_req),
        .trap_pc  (trap_pc),
        .trap_ack (trap_ack)
`ifdef TRAP_UNIT_COUNTER_EN
        ,
        .trap_count    (trap_count),
        .trap_count_clr(tclr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_hit(input logic [4:0] t, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        return (t[4] && sx < sy) || (t[3] && sx > sy) || (t[2] && ux == uy) ||
               (t[1] && ux < uy) || (t[0] && ux > uy);
    endfunction

    task automatic model_reset();
        m_inflight = 0;
        m_pend     = 0;
        m_to       = '0;
        m_a        = '0;
        m_b        = '0;
        m_pc       = '0;
        m_tpc      = '0;
        m_cnt      = '0;
    endtask

    // One clock cycle: drive, check against model, advance model, step clock
    task automatic cyc(input logic v, input logic [4:0] t, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [31:0] ipc, input logic fl,
                       input logic ack, input logic clr,
                       output logic od, output logic ordy, output logic oreq);
        bit h;
        valid_in = v; to = t; a = ia; b = ib; pc = ipc;
        flush = fl; trap_ack = ack; tclr = clr;
        #1;
        od = done; ordy = ready_out; oreq = trap_req;
        h = m_inflight && ref_hit(m_to, m_a, m_b);
        chk("ready_out", {31'd0, ready_out}, {31'd0, !(m_inflight || m_pend)});
        chk("done", {31'd0, done}, {31'd0, m_inflight && !h && !fl});
        chk("trap_req", {31'd0, trap_req}, {31'd0, m_pend});
        chk("trap_pc", trap_pc, m_tpc);
`ifdef TRAP_UNIT_COUNTER_EN
        chk("trap_count", trap_count, m_cnt);
`endif
        if (m_inflight) begin
            m_inflight = 0;
            if (!fl && h) begin
                m_pend = 1;
                m_tpc  = m_pc;
            end
        end else if (m_pend) begin
            if (fl) begin
                m_pend = 0;
            end else if (ack) begin
                m_pend = 0;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
        end else if (v && !fl) begin
            m_inflight = 1;
            m_to = t; m_a = ia; m_b = ib; m_pc = ipc;
        end
        if (clr) m_cnt = '0;
        @(posedge clk);
        #1;
    endtask

    logic od, ordy, oreq;

    initial begin
        reset = 1'b0; valid_in = 0; to = '0; a = '0; b = '0; pc = '0;
        flush = 0; trap_ack = 0; tclr = 0;
        model_reset();
        #1;
        chk("rst_ready", {31'd0, ready_out}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_trap_req", {31'd0, trap_req}, 32'd0);
        chk("rst_trap_pc", trap_pc, 32'd0);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // Signed lt hit, ack at N+4
        cyc(1, 5'b10000, 32'hFFFF_FFFF, 32'd1, 32'h100, 0, 0, 0, od, ordy, oreq);
        chk("slt_hs_ready", {31'd0, ordy}, 32'd1);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        chk("slt_n1_done", {31'd0, od}, 32'd0);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        chk("slt_n2_req", {31'd0, oreq}, 32'd1);
        chk("slt_n2_pc", trap_pc, 32'h100);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 1, 0, od, ordy, oreq);
        chk("slt_n4_req", {31'd0, oreq}, 32'd1);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        chk("slt_n5_req", {31'd0, oreq}, 32'd0);
        chk("slt_n5_ready", {31'd0, ordy}, 32'd1);

        // Unsigned lt on the same operands misses
        cyc(1, 5'b00010, 32'hFFFF_FFFF, 32'd1, 32'h200, 0, 0, 0, od, ordy, oreq);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        chk("ult_done", {31'd0, od}, 32'd1);
        chk("ult_req", {31'd0, oreq}, 32'd0);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        chk("ult_req_after", {31'd0, oreq}, 32'd0);

        // Equality trap, then acknowledge
        cyc(1, 5'b00100, 32'd5, 32'd5, 32'h300, 0, 0, 0, od, ordy, oreq);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 1, 0, od, ordy, oreq);
        chk("eq_req", {31'd0, oreq}, 32'd1);
        chk("eq_pc", trap_pc, 32'h300);
        // TO=0 never hits
        cyc(1, 5'b00000, 32'd5, 32'd5, 32'h304, 0, 0, 0, od, ordy, oreq);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        chk("to0_done", {31'd0, od}, 32'd1);
        // TO=all always hits
        cyc(1, 5'b11111, 32'd3, 32'd7, 32'h308, 0, 0, 0, od, ordy, oreq);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        chk("toall_done", {31'd0, od}, 32'd0);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        chk("toall_req", {31'd0, oreq}, 32'd1);
        // Flush and ack together while pending: flush wins, no count
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 1, 1, 0, od, ordy, oreq);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        chk("flush_req", {31'd0, oreq}, 32'd0);
        chk("flush_done", {31'd0, od}, 32'd0);
`ifdef TRAP_UNIT_COUNTER_EN
        chk("flush_count", trap_count, 32'd2);
`endif

        // Valid held high with three non-trapping instructions
        for (int i = 0; i < 6; i++) begin
            cyc(1, 5'b01000, 32'd1, 32'd9, 32'h400 + 32'(i), 0, 0, 0, od, ordy, oreq);
            chk("b2b_done", {31'd0, od}, {31'd0, 1'(i % 2)});
            chk("b2b_ready", {31'd0, ordy}, {31'd0, 1'((i + 1) % 2)});
        end
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = $urandom_range(0, 8);
                2: rb = ~ra;
                default: rb = $urandom;
            endcase
            cyc(logic'($urandom_range(0, 9) < 6), 5'($urandom), ra, rb, $urandom,
                logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 2) == 0),
                logic'($urandom_range(0, 19) == 0), od, ordy, oreq);
        end

        // Reset while a trap is pending
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 1, 0, 0, od, ordy, oreq);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        cyc(1, 5'b11111, 32'd1, 32'd2, 32'h500, 0, 0, 0, od, ordy, oreq);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 0, 0, od, ordy, oreq);
        chk("pre_rst_req", {31'd0, oreq}, 32'd1);
        valid_in = 0; flush = 0; trap_ack = 0; tclr = 0;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, trap_req}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready_out}, 32'd1);
        chk("mid_rst_pc", trap_pc, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
`ifdef TRAP_UNIT_COUNTER_EN
        chk("mid_rst_count", trap_count, 32'd0);
`endif
        model_reset();
        #1 reset = 1'b1;
        @(posedge clk); #1;
        cyc(0, 5'b0, 32'd0, 32'd0, 32'd0, 0, 1, 0, od, ordy, oreq);
        chk("post_rst_req", {31'd0, oreq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
